// File: rtl/game_sequencer_if.sv
// Signal bundle between the breakout sequencer and its surroundings: button and
// collision events go in, ball control and display status come out.
interface game_sequencer_if #(
  parameter int unsigned SCORE_W = 12
);
  logic               tick;
  logic               start;
  logic               block_hit;
  logic               floor_hit;
  logic [2:0]         state;
  logic               ball_run;
  logic               ball_reset;
  logic [1:0]         lives;
  logic [5:0]         blocks_left;
  logic [SCORE_W-1:0] score;
  logic               paused;

  modport master (
    output tick, start, block_hit, floor_hit,
    input  state, ball_run, ball_reset, lives, blocks_left, score, paused
  );

  modport slave (
    input  tick, start, block_hit, floor_hit,
    output state, ball_run, ball_reset, lives, blocks_left, score, paused
  );
endinterface

// File: rtl/game_sequencer.sv
// Breakout game sequencer: serve/play/miss flow, lives, score and brick count.
// All outputs are registered.
module game_sequencer #(
  parameter int unsigned NUM_BLOCKS  = 60,
  parameter int unsigned INIT_LIVES  = 3,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned BLOCK_PTS   = 10,
  parameter int unsigned SCORE_W     = 12
) (
  input logic            clk,
  input logic            rst,
  game_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StMiss  = 3'd3,
    StOver  = 3'd4,
    StWin   = 3'd5
  } state_e;

  localparam logic [SCORE_W:0] PtsExt = (SCORE_W + 1)'(BLOCK_PTS);

  state_e             state_q;
  logic [7:0]         serve_cnt_q;
  logic [1:0]         lives_q;
  logic [5:0]         blocks_q;
  logic [SCORE_W-1:0] score_q;
  logic               ball_run_q;
  logic               ball_reset_q;
  logic               paused_q;
  logic               start_prev_q;
  logic               start_rise;
  logic [SCORE_W:0]   score_sum;

  assign start_rise = bus.start & ~start_prev_q;
  assign score_sum  = {1'b0, score_q} + PtsExt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      serve_cnt_q  <= 8'(SERVE_DELAY);
      lives_q      <= 2'(INIT_LIVES);
      blocks_q     <= 6'(NUM_BLOCKS);
      score_q      <= '0;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b0;
      paused_q     <= 1'b0;
      // Preset high so a button held through reset is not seen as a press.
      start_prev_q <= 1'b1;
    end else begin
      start_prev_q <= bus.start;
      ball_reset_q <= 1'b0;
      unique case (state_q)
        StIdle, StOver, StWin: begin
          if (start_rise) begin
            state_q      <= StServe;
            lives_q      <= 2'(INIT_LIVES);
            blocks_q     <= 6'(NUM_BLOCKS);
            score_q      <= '0;
            serve_cnt_q  <= 8'(SERVE_DELAY);
            ball_reset_q <= 1'b1;
            ball_run_q   <= 1'b0;
          end
        end
        StServe: begin
          if (bus.tick) begin
            if (serve_cnt_q == 8'd1) begin
              state_q    <= StPlay;
              ball_run_q <= 1'b1;
            end else begin
              serve_cnt_q <= serve_cnt_q - 8'd1;
            end
          end
        end
        StPlay: begin
          if (bus.block_hit) begin
            blocks_q <= blocks_q - 6'd1;
            score_q  <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          end
          // Last brick wins even if the ball also reached the floor.
          if (bus.block_hit && blocks_q == 6'd1) begin
            state_q    <= StWin;
            paused_q   <= 1'b0;
            ball_run_q <= 1'b0;
          end else if (bus.floor_hit) begin
            state_q    <= StMiss;
            lives_q    <= lives_q - 2'd1;
            paused_q   <= 1'b0;
            ball_run_q <= 1'b0;
          end else if (start_rise) begin
            paused_q   <= ~paused_q;
            ball_run_q <= paused_q;
          end
        end
        StMiss: begin
          if (lives_q == 2'd0) begin
            state_q <= StOver;
          end else begin
            state_q      <= StServe;
            serve_cnt_q  <= 8'(SERVE_DELAY);
            ball_reset_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.ball_run    = ball_run_q;
  assign bus.ball_reset  = ball_reset_q;
  assign bus.lives       = lives_q;
  assign bus.blocks_left = blocks_q;
  assign bus.score       = score_q;
  assign bus.paused      = paused_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: serve timing, scoring, misses, pause,
// win priority and asynchronous reset.
module tb_game_sequencer;

  logic clk;
  logic rst;
  int   vectors;
  int   errs;

  game_sequencer_if #(.SCORE_W(12)) bus ();

  game_sequencer #(
    .NUM_BLOCKS (60),
    .INIT_LIVES (3),
    .SERVE_DELAY(60),
    .BLOCK_PTS  (10),
    .SCORE_W    (12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
  endtask

  task automatic serve_to_play();
    bus.tick = 1'b1;
    repeat (60) step();
    bus.tick = 1'b0;
  endtask

  task automatic hit_blocks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.block_hit = 1'b1;
      step();
    end
    bus.block_hit = 1'b0;
  endtask

  task automatic floor_to_serve();
    bus.floor_hit = 1'b1;
    step();
    bus.floor_hit = 1'b0;
    step();
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    rst     = 1'b1;
    bus.tick      = 1'b0;
    bus.start     = 1'b0;
    bus.block_hit = 1'b0;
    bus.floor_hit = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_lives", 32'(bus.lives), 3);
    chk("rst_blocks", 32'(bus.blocks_left), 60);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_run", 32'(bus.ball_run), 0);
    chk("rst_breset", 32'(bus.ball_reset), 0);
    chk("rst_paused", 32'(bus.paused), 0);

    // Start game: first SERVE cycle carries the recentre pulse.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("serve_state", 32'(bus.state), 1);
    chk("serve_breset", 32'(bus.ball_reset), 1);
    // Hit during SERVE is ignored; the recentre pulse has ended.
    bus.block_hit = 1'b1;
    step();
    bus.block_hit = 1'b0;
    chk("serve_breset_end", 32'(bus.ball_reset), 0);
    chk("serve_hit_blocks", 32'(bus.blocks_left), 60);
    chk("serve_hit_score", 32'(bus.score), 0);
    bus.tick = 1'b1;
    repeat (59) step();
    chk("serve_59_state", 32'(bus.state), 1);
    chk("serve_59_run", 32'(bus.ball_run), 0);
    step();
    bus.tick = 1'b0;
    chk("play_state", 32'(bus.state), 2);
    chk("play_run", 32'(bus.ball_run), 1);
    chk("play_lives", 32'(bus.lives), 3);

    hit_blocks(3);
    chk("hit3_blocks", 32'(bus.blocks_left), 57);
    chk("hit3_score", 32'(bus.score), 30);

    // First miss: PLAY -> MISS -> SERVE.
    bus.floor_hit = 1'b1;
    step();
    bus.floor_hit = 1'b0;
    chk("miss1_state", 32'(bus.state), 3);
    chk("miss1_lives", 32'(bus.lives), 2);
    chk("miss1_run", 32'(bus.ball_run), 0);
    step();
    chk("miss1_serve", 32'(bus.state), 1);
    chk("miss1_breset", 32'(bus.ball_reset), 1);
    step();
    chk("miss1_breset_end", 32'(bus.ball_reset), 0);
    chk("miss1_score_kept", 32'(bus.score), 30);
    serve_to_play();
    chk("replay_state", 32'(bus.state), 2);

    // Pause toggling; hits still count while paused.
    press();
    chk("pause_on", 32'(bus.paused), 1);
    chk("pause_run", 32'(bus.ball_run), 0);
    hit_blocks(1);
    chk("pause_hit_blocks", 32'(bus.blocks_left), 56);
    chk("pause_hit_score", 32'(bus.score), 40);
    press();
    chk("pause_off", 32'(bus.paused), 0);
    chk("pause_off_run", 32'(bus.ball_run), 1);
    press();
    bus.floor_hit = 1'b1;
    step();
    bus.floor_hit = 1'b0;
    chk("pmiss_state", 32'(bus.state), 3);
    chk("pmiss_paused", 32'(bus.paused), 0);
    chk("pmiss_lives", 32'(bus.lives), 1);
    step();
    serve_to_play();

    // Last life lost.
    floor_to_serve();
    chk("over_state", 32'(bus.state), 4);
    chk("over_lives", 32'(bus.lives), 0);
    chk("over_run", 32'(bus.ball_run), 0);
    hit_blocks(1);
    chk("over_hit_blocks", 32'(bus.blocks_left), 56);
    chk("over_hit_score", 32'(bus.score), 40);
    press();
    chk("restart_state", 32'(bus.state), 1);
    chk("restart_lives", 32'(bus.lives), 3);
    chk("restart_score", 32'(bus.score), 0);
    chk("restart_blocks", 32'(bus.blocks_left), 60);
    serve_to_play();

    // Last brick together with floor: WIN beats MISS.
    hit_blocks(59);
    chk("b59_blocks", 32'(bus.blocks_left), 1);
    chk("b59_score", 32'(bus.score), 590);
    bus.block_hit = 1'b1;
    bus.floor_hit = 1'b1;
    step();
    bus.block_hit = 1'b0;
    bus.floor_hit = 1'b0;
    chk("win_state", 32'(bus.state), 5);
    chk("win_lives", 32'(bus.lives), 3);
    chk("win_blocks", 32'(bus.blocks_left), 0);
    chk("win_score", 32'(bus.score), 600);
    chk("win_run", 32'(bus.ball_run), 0);

    // Third game: build score 120 and lives 1, then reset mid-play.
    press();
    chk("win_restart_state", 32'(bus.state), 1);
    serve_to_play();
    hit_blocks(12);
    floor_to_serve();
    serve_to_play();
    floor_to_serve();
    serve_to_play();
    chk("pre_rst_score", 32'(bus.score), 120);
    chk("pre_rst_lives", 32'(bus.lives), 1);
    chk("pre_rst_state", 32'(bus.state), 2);
    bus.start = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(bus.state), 0);
    chk("arst_lives", 32'(bus.lives), 3);
    chk("arst_score", 32'(bus.score), 0);
    chk("arst_blocks", 32'(bus.blocks_left), 60);
    chk("arst_run", 32'(bus.ball_run), 0);
    chk("arst_paused", 32'(bus.paused), 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("held_start_idle", 32'(bus.state), 0);
    bus.start = 1'b0;
    step();
    press();
    chk("post_rst_start", 32'(bus.state), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
